// File: rtl/sigdel_dac_ctrl.sv
// Sample-rate scheduler/feeder for the first-order sigma-delta DAC modulator.
// Latency: popped sample appears on dac_code one cycle after sample_tick; s_ready is combinational.
// Backpressure: s_ready drops when the FIFO is full or the controller is idle.
// Optional soft start/stop ramps are built when SIGDEL_CTRL_RAMP_EN is defined.
module sigdel_dac_ctrl #(
  parameter int BITLEN   = 16,
  parameter int OSR_W    = 16,
  parameter int FIFO_AW  = 3,
  parameter int RAMP_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [OSR_W-1:0]  osr_div,
  input  logic [BITLEN-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [BITLEN-1:0] dac_code,
  output logic              sample_tick,
  output logic              underflow,
  output logic              underflow_seen,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int AT_W  = (RAMP_MAX > 0) ? $clog2(RAMP_MAX + 1) : 1;
  localparam logic [BITLEN-1:0] MIDSCALE = {1'b1, {(BITLEN-1){1'b0}}};
  localparam logic [FIFO_AW:0]  LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]  LVL_HALF = (FIFO_AW+1)'(DEPTH / 2);

  typedef enum logic [2:0] {IDLE, PRIME, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t                   state, state_nxt;
  logic [OSR_W-1:0]         cnt;
  logic [BITLEN-1:0]        mem [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr, rd_ptr;
  logic [FIFO_AW:0]         count;
  logic [AT_W-1:0]          atten;
  logic [AT_W-1:0]          out_atten;
  logic                     tick, active, empty, full;
  logic                     push, pop, pop_req, flush;
  logic signed [BITLEN-1:0] shifted;
  logic [BITLEN-1:0]        conv_code;

`ifdef SIGDEL_CTRL_RAMP_EN
  logic [AT_W-1:0]          atten_nxt;
  localparam logic [AT_W-1:0] AT_MAX = AT_W'(RAMP_MAX);
`else
  assign atten = '0;
`endif

  // Status, divider strobe and FIFO handshake decode
  always_comb begin
    empty       = (count == '0);
    full        = (count == LVL_FULL);
    active      = (state == RAMP_UP) || (state == RUN) || (state == RAMP_DOWN);
    tick        = (state != IDLE) && (cnt >= osr_div);
    sample_tick = tick;
    underflow   = tick && active && empty;
    s_ready     = !full && (state != IDLE);
    push        = s_valid && s_ready;
    pop         = pop_req && !empty;
    flush       = (state != IDLE) && (state_nxt == IDLE);
    busy        = (state != IDLE);
    fifo_level  = count;
  end

  // Next-state, pop request and attenuation stepping
  always_comb begin
    state_nxt = state;
    pop_req   = 1'b0;
    out_atten = atten;
`ifdef SIGDEL_CTRL_RAMP_EN
    atten_nxt = atten;
`endif
    case (state)
      IDLE: begin
        if (enable) state_nxt = PRIME;
      end
      PRIME: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (count >= LVL_HALF) begin
`ifdef SIGDEL_CTRL_RAMP_EN
          state_nxt = RAMP_UP;
`else
          state_nxt = RUN;
`endif
        end
      end
`ifdef SIGDEL_CTRL_RAMP_EN
      RAMP_UP: begin
        // Output at the current shift, then step towards full scale.
        // Losing enable freezes the shift so the descent starts from here.
        if (tick) begin
          pop_req = 1'b1;
          if (enable) begin
            if (atten == '0) state_nxt = RUN;
            else             atten_nxt = atten - AT_W'(1);
          end
        end
        if (!enable) state_nxt = RAMP_DOWN;
      end
      RUN: begin
        pop_req = tick;
        if (!enable) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        // Step the shift first so every descending output is quieter.
        // A tick already at full attenuation ends playback.
        if (tick) begin
          if (atten == AT_MAX) begin
            state_nxt = enable ? RAMP_UP : IDLE;
          end else begin
            atten_nxt = atten + AT_W'(1);
            out_atten = atten + AT_W'(1);
            pop_req   = 1'b1;
            state_nxt = enable ? RAMP_UP : RAMP_DOWN;
          end
        end else if (enable) begin
          state_nxt = RAMP_UP;
        end
      end
`else
      RUN: begin
        pop_req = tick;
        if (!enable) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Signed sample to offset-binary code at the selected attenuation
  always_comb begin
    shifted   = $signed(mem[rd_ptr]) >>> out_atten;
    conv_code = {~shifted[BITLEN-1], shifted[BITLEN-2:0]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sample-period divider; restarts when playback begins so the first tick is a full period away
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == IDLE) || (state_nxt == IDLE) ||
                 ((state == PRIME) && (state_nxt != PRIME))) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + OSR_W'(1);
    end
  end

  // FIFO pointers and occupancy; leaving playback discards buffered samples
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // Registered DAC code: midscale when stopping, new sample on pop, otherwise hold
  always_ff @(posedge clk) begin
    if (rst)                    dac_code <= MIDSCALE;
    else if (state_nxt == IDLE) dac_code <= MIDSCALE;
    else if (pop)               dac_code <= conv_code;
  end

  // Sticky underflow flag, cleared when a new play request starts priming
  always_ff @(posedge clk) begin
    if (rst)                                       underflow_seen <= 1'b0;
    else if ((state == IDLE) && (state_nxt == PRIME)) underflow_seen <= 1'b0;
    else if (underflow)                            underflow_seen <= 1'b1;
  end

`ifdef SIGDEL_CTRL_RAMP_EN
  // Attenuation register; idle parks it at full attenuation for the next start
  always_ff @(posedge clk) begin
    if (rst)                    atten <= AT_MAX;
    else if (state_nxt == IDLE) atten <= AT_MAX;
    else                        atten <= atten_nxt;
  end
`endif

endmodule

// File: doc/sigdel_dac_ctrl.md
# sigdel_dac_ctrl

Sample-rate scheduler and feeder for the first-order sigma-delta DAC modulator. Buffers signed PCM samples from an upstream valid/ready source in a small FIFO and releases one sample every `osr_div+1` clocks. Converts each sample to the modulator's unsigned offset-binary input code. Sequences start/stop through an FSM with optional soft attenuation ramps, and substitutes midscale (silence) whenever the modulator is not running.

## Interface
- `BITLEN`, default 16: sample and DAC code width.
- `OSR_W`, default 16: width of the sample-period divider.
- `FIFO_AW`, default 3: FIFO address width; depth = 2^FIFO_AW.
- `RAMP_MAX`, default 8: maximum attenuation shift; must be < BITLEN.
- Clock and reset (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous active-high reset.
- `enable`, input, 1: level request to play.
- `osr_div`, input, OSR_W: sample period minus one, in clk cycles.
- `s_data`, input, BITLEN: signed two's-complement sample.
- `s_valid`, input, 1: `s_data` valid.
- `s_ready`, output, 1: FIFO can accept data.
- `dac_code`, output, BITLEN: registered offset-binary code, wired to the modulator `in_DAC`.
- `sample_tick`, output, 1: one-cycle sample strobe.
- `underflow`, output, 1: one-cycle pulse when a tick finds the FIFO empty.
- `underflow_seen`, output, 1: sticky underflow flag.
- `fifo_level`, output, FIFO_AW+1: current FIFO occupancy.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- **Conversion:** `v = s >>> atten` (arithmetic shift). Output code = `{~v[BITLEN-1], v[BITLEN-2:0]}`. Midscale = `1 << (BITLEN-1)`.
- **Divider:** counter `cnt` runs only outside IDLE.
  - Tick when `cnt >= osr_div`; `cnt` then reloads to 0, otherwise it increments.
  - `osr_div = 0` gives a tick every cycle.
  - A live `osr_div` decrease below `cnt` ticks on the next cycle.
- **FIFO:**
  - Push when `s_valid && s_ready`.
  - `s_ready = !full && state != IDLE` (combinational from state and count).
  - Pop only on a tick in RAMP_UP, RUN or RAMP_DOWN with FIFO non-empty.
  - When full, push is blocked even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - Entering IDLE flushes the FIFO.
- **FSM:**
  - **IDLE:** `dac_code` = midscale, `atten` = RAMP_MAX. `enable` → PRIME.
  - **PRIME:** accept data, no pops, `dac_code` stays midscale. `fifo_level >= 2^(FIFO_AW-1)` → RAMP_UP; `!enable` → IDLE.
  - **RAMP_UP:** each tick pops and outputs the sample at the current `atten`, then decrements `atten`.
    - A tick at `atten == 0` outputs unattenuated and moves to RUN.
    - `!enable` → RAMP_DOWN, keeping the current `atten`.
  - **RUN:** each tick pops and outputs with `atten = 0`. `!enable` → RAMP_DOWN.
  - **RAMP_DOWN:** each tick increments `atten`, then pops and outputs at the new `atten`.
    - When `atten` reaches RAMP_MAX, the next tick → IDLE.
    - `enable` → RAMP_UP from the current `atten` (no step discontinuity).
- **Underflow:** a tick with the FIFO empty in RAMP_UP/RUN/RAMP_DOWN holds `dac_code`, pulses `underflow` and sets `underflow_seen`. `atten` still steps.
- `underflow_seen` clears on the IDLE→PRIME transition.

## Timing
- Reset values: `dac_code` = midscale, state = IDLE, `cnt` = 0, FIFO empty, `atten` = RAMP_MAX, `s_ready` = 0, `sample_tick` = 0, `underflow` = 0, `underflow_seen` = 0, `busy` = 0.
- `sample_tick` and `underflow` are asserted combinationally in the tick cycle.
- `dac_code` updates on the clock edge ending the tick cycle, so the popped sample is visible one cycle after `sample_tick`.
- The first tick occurs `osr_div+1` cycles after entering RAMP_UP, because `cnt` is cleared on the PRIME→RAMP_UP transition.
- State changes take effect at the clock edge following the causing condition.
- `enable` edges are acted on regardless of tick alignment.
- `rst` mid-operation forces all reset values on the next edge; FIFO contents are discarded.

## Configuration
- `SIGDEL_CTRL_RAMP_EN` defined: ramp states and `atten` logic as above.
- Undefined: `atten` is constant 0.
  - PRIME → RUN directly.
  - RUN with `!enable` → IDLE on the next edge, so `dac_code` returns to midscale immediately.
  - RAMP_UP and RAMP_DOWN are unreachable and their logic is compiled out.

## Test plan
All scenarios use BITLEN=16, FIFO_AW=3, RAMP_MAX=8, `osr_div=3`, with ramp enabled unless stated.
- **Reset/idle:** assert `rst` 2 cycles → `dac_code=0x8000`, `s_ready=0`, `busy=0`; with `enable=0`, pushes are refused.
- **Prime and ramp:** `enable=1`, stream constant `0x4000` → PRIME until level 4, then the first code is `0x8040` (atten 8), then `0x8080`, `0x8100`, … up to `0xC000` on the 9th tick. Ticks are exactly every 4 cycles.
- **Underflow:** in RUN, stop `s_valid` → after the FIFO drains, each tick pulses `underflow`, `dac_code` holds its last value, and `underflow_seen=1` until the next IDLE→PRIME.
- **Stop/reverse:** drop `enable` in RUN, then reassert it after 3 ticks → `atten` goes 1, 2, 3, then decrements from 3 without a jump; with no reassert, 8 ramp ticks then IDLE with code `0x8000`.
- **Full FIFO:** hold `s_valid=1` in RUN → `s_ready` drops at level 8, and a same-cycle pop does not allow a push; negative sample `0x8000` at atten 0 → code `0x0000`.
- **Macro off:** `SIGDEL_CTRL_RAMP_EN` undefined → first code after PRIME is `0xC000`, and `enable=0` gives `0x8000` on the next edge.
